// File: rtl/password_fsm.sv
`default_nettype none
// ============================================================================
// Module      : password_fsm
// Description : Four-digit BCD keypad lock. Collects digits from a one-shot
//               keypad stage, compares the completed entry against PASSWORD,
//               then shows UNLOCKED or DENIED for HOLD_CYCLES cycles. After
//               MAX_TRIES consecutive failures it enters LOCKOUT for
//               LOCK_CYCLES cycles.
//
// Ports       : clk          in   system clock, rising edge
//               rst          in   asynchronous reset, active low
//               digit_valid  in   single-cycle digit strobe
//               digit        in   [3:0] digit value (values > 9 ignored)
//               entered      out  [15:0] digits accepted so far (HEX display)
//               digit_count  out  [2:0] digits accepted in current entry
//               unlocked     out  high while in UNLOCKED
//               denied       out  high while in DENIED
//               locked_out   out  high while in LOCKOUT
//               fail_count   out  [2:0] consecutive failed attempts
//               state        out  [2:0] current state encoding
//
// Revision    : 1.0  initial release
// ============================================================================
module password_fsm #(
    parameter logic [15:0] PASSWORD    = 16'h1234,
    parameter int          MAX_TRIES   = 3,
    parameter int          HOLD_CYCLES = 100_000_000,
    parameter int          LOCK_CYCLES = 500_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    output logic [15:0] entered,
    output logic [2:0]  digit_count,
    output logic        unlocked,
    output logic        denied,
    output logic        locked_out,
    output logic [2:0]  fail_count,
    output logic [2:0]  state
);

    // State encoding is visible on the state output, so it is fixed here.
    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_ENTRY    = 3'd1;
    localparam logic [2:0] c_CHECK    = 3'd2;
    localparam logic [2:0] c_UNLOCKED = 3'd3;
    localparam logic [2:0] c_DENIED   = 3'd4;
    localparam logic [2:0] c_LOCKOUT  = 3'd5;

    // One shared down-counter serves all timed states. It is loaded with
    // N-1 on entry and the state is left when it reads zero, giving exactly
    // N cycles in the timed state.
    localparam int c_MAX_CYCLES = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
    localparam int c_TIMER_W    = $clog2(c_MAX_CYCLES);

    localparam logic [c_TIMER_W-1:0] c_HOLD_LOAD = c_TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_LOCK_LOAD = c_TIMER_W'(LOCK_CYCLES - 1);
    localparam logic [3:0]           c_MAX_TRIES = 4'(MAX_TRIES);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]           r_state;
    logic [15:0]          r_entered;
    logic [2:0]           r_digit_count;
    logic [2:0]           r_fail_count;
    logic [c_TIMER_W-1:0] r_timer;
    logic                 r_unlocked;
    logic                 r_denied;
    logic                 r_locked_out;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    logic [2:0]           w_next_state;
    logic [15:0]          w_next_entered;
    logic [2:0]           w_next_count;
    logic [2:0]           w_next_fail;
    logic [c_TIMER_W-1:0] w_next_timer;
    logic                 w_digit_ok;
    logic [3:0]           w_fail_inc;

    // Non-BCD codes are dropped up front so no state ever sees them.
    assign w_digit_ok = digit_valid && (digit <= 4'd9);

    // One bit wider than fail_count so MAX_TRIES up to 7 compares cleanly.
    assign w_fail_inc = {1'b0, r_fail_count} + 4'd1;

    always_comb begin
        w_next_state   = r_state;
        w_next_entered = r_entered;
        w_next_count   = r_digit_count;
        w_next_fail    = r_fail_count;
        w_next_timer   = r_timer;

        case (r_state)
            c_IDLE: begin
                w_next_entered = '0;
                w_next_count   = '0;
                if (w_digit_ok) begin
                    w_next_entered = {12'h000, digit};
                    w_next_count   = 3'd1;
                    w_next_state   = c_ENTRY;
                end
            end

            c_ENTRY: begin
                if (w_digit_ok) begin
                    w_next_entered = {r_entered[11:0], digit};
                    w_next_count   = r_digit_count + 3'd1;
                    // Three digits already held: this one completes the code.
                    if (r_digit_count == 3'd3) begin
                        w_next_state = c_CHECK;
                    end
                end
            end

            // Single-cycle decision; the keypad is not looked at here.
            c_CHECK: begin
                if (r_entered == PASSWORD) begin
                    w_next_state = c_UNLOCKED;
                    w_next_fail  = '0;
                    w_next_timer = c_HOLD_LOAD;
                end else if (w_fail_inc < c_MAX_TRIES) begin
                    w_next_state = c_DENIED;
                    w_next_fail  = w_fail_inc[2:0];
                    w_next_timer = c_HOLD_LOAD;
                end else begin
                    w_next_state = c_LOCKOUT;
                    w_next_fail  = '0;
                    w_next_timer = c_LOCK_LOAD;
                end
            end

            // entered/digit_count keep their CHECK values for display while
            // the timer runs; keypad activity is ignored entirely.
            c_UNLOCKED, c_DENIED, c_LOCKOUT: begin
                if (r_timer == '0) begin
                    w_next_state   = c_IDLE;
                    w_next_entered = '0;
                    w_next_count   = '0;
                end else begin
                    w_next_timer = r_timer - 1'b1;
                end
            end

            // Encodings 6 and 7 fall back to a clean IDLE.
            default: begin
                w_next_state   = c_IDLE;
                w_next_entered = '0;
                w_next_count   = '0;
                w_next_timer   = '0;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up
    // exactly with the registered state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_IDLE;
            r_entered     <= '0;
            r_digit_count <= '0;
            r_fail_count  <= '0;
            r_timer       <= '0;
            r_unlocked    <= 1'b0;
            r_denied      <= 1'b0;
            r_locked_out  <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_entered     <= w_next_entered;
            r_digit_count <= w_next_count;
            r_fail_count  <= w_next_fail;
            r_timer       <= w_next_timer;
            r_unlocked    <= (w_next_state == c_UNLOCKED);
            r_denied      <= (w_next_state == c_DENIED);
            r_locked_out  <= (w_next_state == c_LOCKOUT);
        end
    end

    assign state       = r_state;
    assign entered     = r_entered;
    assign digit_count = r_digit_count;
    assign fail_count  = r_fail_count;
    assign unlocked    = r_unlocked;
    assign denied      = r_denied;
    assign locked_out  = r_locked_out;

endmodule
`default_nettype wire

// File: tb/tb_password_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_password_fsm
// Description : Directed self-checking bench for password_fsm with
//               HOLD_CYCLES=4, LOCK_CYCLES=8, MAX_TRIES=3.
// Revision    : 1.0  initial release
// ============================================================================
module tb_password_fsm;

    localparam int c_HOLD = 4;
    localparam int c_LOCK = 8;

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_CHECK    = 3'd2;
    localparam logic [2:0] c_UNLOCKED = 3'd3;
    localparam logic [2:0] c_DENIED   = 3'd4;
    localparam logic [2:0] c_LOCKOUT  = 3'd5;

    logic        clk;
    logic        rst;
    logic        digit_valid;
    logic [3:0]  digit;
    logic [15:0] entered;
    logic [2:0]  digit_count;
    logic        unlocked;
    logic        denied;
    logic        locked_out;
    logic [2:0]  fail_count;
    logic [2:0]  state;

    int n_checks;
    int n_errors;

    password_fsm #(
        .PASSWORD    (16'h1234),
        .MAX_TRIES   (3),
        .HOLD_CYCLES (c_HOLD),
        .LOCK_CYCLES (c_LOCK)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .digit_valid (digit_valid),
        .digit       (digit),
        .entered     (entered),
        .digit_count (digit_count),
        .unlocked    (unlocked),
        .denied      (denied),
        .locked_out  (locked_out),
        .fail_count  (fail_count),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] d);
        digit       = d;
        digit_valid = 1'b1;
        cyc();
        digit_valid = 1'b0;
        digit       = 4'd0;
    endtask

    // Four isolated pulses; returns in the CHECK cycle.
    task automatic enter_code(input logic [15:0] code);
        logic [15:0] c;
        c = code;
        for (int i = 0; i < 4; i++) begin
            pulse(c[15:12]);
            c = c << 4;
            if (i < 3) cyc();
        end
    endtask

    // Called in the first cycle of a timed state; measures how long the
    // matching flag stays high and checks the return to a clean IDLE.
    task automatic run_hold(input logic [2:0] exp_state, input int exp_len,
                            input logic [15:0] exp_entered, input bit inject,
                            input string tag);
        int   n;
        logic flag;
        n = 0;
        flag = (exp_state == c_UNLOCKED) ? unlocked :
               (exp_state == c_DENIED)   ? denied : locked_out;
        while (flag && n < 40) begin
            if (n == 2) begin
                check({tag, "_state"},   32'(state),   32'(exp_state));
                check({tag, "_entered"}, 32'(entered), 32'(exp_entered));
            end
            digit_valid = inject && (n == 1);
            digit       = 4'd7;
            cyc();
            n++;
            flag = (exp_state == c_UNLOCKED) ? unlocked :
                   (exp_state == c_DENIED)   ? denied : locked_out;
        end
        digit_valid = 1'b0;
        digit       = 4'd0;
        check({tag, "_len"},        32'(n),           32'(exp_len));
        check({tag, "_idle"},       32'(state),       32'(c_IDLE));
        check({tag, "_idle_ent"},   32'(entered),     32'd0);
        check({tag, "_idle_count"}, 32'(digit_count), 32'd0);
    endtask

    task automatic attempt(input logic [15:0] code, input logic [2:0] exp_state,
                           input int exp_len, input logic [2:0] exp_fail,
                           input bit inject, input string tag);
        enter_code(code);
        check({tag, "_check"},   32'(state),       32'(c_CHECK));
        check({tag, "_code"},    32'(entered),     32'(code));
        check({tag, "_count4"},  32'(digit_count), 32'd4);
        cyc();
        check({tag, "_outcome"}, 32'(state),       32'(exp_state));
        check({tag, "_fail"},    32'(fail_count),  32'(exp_fail));
        run_hold(exp_state, exp_len, code, inject, tag);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b0;
        digit_valid = 1'b0;
        digit       = 4'd0;

        // Reset state
        cyc();
        cyc();
        check("rst_state",  32'(state),       32'(c_IDLE));
        check("rst_entered", 32'(entered),    32'd0);
        check("rst_count",  32'(digit_count), 32'd0);
        check("rst_fail",   32'(fail_count),  32'd0);
        check("rst_flags",  32'({unlocked, denied, locked_out}), 32'd0);
        rst = 1'b1;
        cyc();

        // Correct code
        attempt(16'h1234, c_UNLOCKED, c_HOLD, 3'd0, 1'b0, "ok1");
        cyc();

        // Wrong code, with a keypad pulse during DENIED
        attempt(16'h1235, c_DENIED, c_HOLD, 3'd1, 1'b1, "bad1");
        cyc();

        // Second failure, then a correct code clears the count
        attempt(16'h1236, c_DENIED,   c_HOLD, 3'd2, 1'b0, "bad2");
        attempt(16'h1234, c_UNLOCKED, c_HOLD, 3'd0, 1'b0, "ok2");

        // Three fresh failures are needed for lockout
        attempt(16'h9999, c_DENIED,  c_HOLD, 3'd1, 1'b0, "lk1");
        attempt(16'h0000, c_DENIED,  c_HOLD, 3'd2, 1'b0, "lk2");
        attempt(16'h4321, c_LOCKOUT, c_LOCK, 3'd0, 1'b1, "lk3");
        attempt(16'h1234, c_UNLOCKED, c_HOLD, 3'd0, 1'b0, "ok3");

        // Non-BCD digit ignored; pulse during CHECK ignored
        pulse(4'd1);
        cyc();
        pulse(4'hB);
        check("nbcd_count", 32'(digit_count), 32'd1);
        check("nbcd_ent",   32'(entered),     32'h1);
        cyc();
        pulse(4'd2);
        cyc();
        pulse(4'd3);
        check("nbcd_count3", 32'(digit_count), 32'd3);
        check("nbcd_ent3",   32'(entered),     32'h123);
        cyc();
        pulse(4'd4);
        check("nbcd_check", 32'(state),       32'(c_CHECK));
        check("nbcd_count4", 32'(digit_count), 32'd4);
        pulse(4'd9);
        check("chk_ign_state", 32'(state),   32'(c_UNLOCKED));
        check("chk_ign_ent",   32'(entered), 32'h1234);
        run_hold(c_UNLOCKED, c_HOLD, 16'h1234, 1'b0, "nbcd");

        // Asynchronous reset mid-entry
        pulse(4'd1);
        cyc();
        pulse(4'd2);
        check("mid_count", 32'(digit_count), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check("arst1_state", 32'(state),       32'(c_IDLE));
        check("arst1_ent",   32'(entered),     32'd0);
        check("arst1_count", 32'(digit_count), 32'd0);
        cyc();
        rst = 1'b1;
        cyc();
        attempt(16'h1234, c_UNLOCKED, c_HOLD, 3'd0, 1'b0, "arst1_ok");

        // Asynchronous reset mid-lockout
        attempt(16'h1111, c_DENIED, c_HOLD, 3'd1, 1'b0, "al1");
        attempt(16'h1112, c_DENIED, c_HOLD, 3'd2, 1'b0, "al2");
        enter_code(16'h1113);
        cyc();
        check("al3_lock", 32'(locked_out), 32'd1);
        cyc();
        cyc();
        #2;
        rst = 1'b0;
        #1;
        check("arst2_state", 32'(state), 32'(c_IDLE));
        check("arst2_flags", 32'({unlocked, denied, locked_out}), 32'd0);
        check("arst2_ent",   32'(entered),    32'd0);
        check("arst2_fail",  32'(fail_count), 32'd0);
        cyc();
        rst = 1'b1;
        cyc();
        attempt(16'h1234, c_UNLOCKED, c_HOLD, 3'd0, 1'b0, "arst2_ok");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/password_fsm.md
PASSWORD_FSM -- requirements
Module: password_fsm

Interface
REQ-001 Parameter PASSWORD, default 16'h1234, four BCD digits; first-entered digit is [15:12].
REQ-002 Parameter MAX_TRIES, default 3, consecutive failures that trigger lockout (range 1..7).
REQ-003 Parameter HOLD_CYCLES, default 100_000_000, duration of UNLOCKED and DENIED display (range >= 2).
REQ-004 Parameter LOCK_CYCLES, default 500_000_000, lockout duration (range >= 2).
REQ-005 clk  in  1  system clock, 50 MHz; single clock domain; all logic rising-edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 digit_valid  in  1  single-cycle pulse from the upstream one-shot stage; already synchronous to clk.
REQ-008 digit  in  4  digit value, sampled only when digit_valid=1.
REQ-009 entered  out  16  digits accepted so far, left-shifted in 4-bit steps, for HEX display.
REQ-010 digit_count  out  3  number of digits accepted in the current entry, 0..4.
REQ-011 unlocked  out  1  high while in UNLOCKED.
REQ-012 denied  out  1  high while in DENIED.
REQ-013 locked_out  out  1  high while in LOCKOUT.
REQ-014 fail_count  out  3  consecutive failed attempts, 0..MAX_TRIES-1.
REQ-015 state  out  3  state encoding: IDLE=0, ENTRY=1, CHECK=2, UNLOCKED=3, DENIED=4, LOCKOUT=5.

Function
REQ-016 All outputs shall be registered; no combinational path from an input to any output.
REQ-017 A digit_valid pulse with digit > 9 shall be ignored in every state, with no change to any register.
REQ-018 IDLE: entered=0, digit_count=0; a valid digit shall load entered={12'h000,digit}, set digit_count=1, and move to ENTRY.
REQ-019 ENTRY: each valid digit shall set entered={entered[11:0],digit} and increment digit_count; the 4th digit shall move to CHECK on the same edge.
REQ-020 CHECK shall last exactly one cycle; digit_valid during CHECK shall be ignored.
REQ-021 CHECK with entered==PASSWORD: next state UNLOCKED, fail_count cleared to 0.
REQ-022 CHECK mismatch with fail_count+1 < MAX_TRIES: next state DENIED, fail_count incremented.
REQ-023 CHECK mismatch with fail_count+1 == MAX_TRIES: next state LOCKOUT, fail_count cleared to 0.
REQ-024 Latency: 4th-digit pulse sampled on edge N shall give state=CHECK after N and unlocked/denied/locked_out asserted after edge N+1.
REQ-025 UNLOCKED and DENIED shall each last exactly HOLD_CYCLES cycles, then return to IDLE with entered=0 and digit_count=0.
REQ-026 LOCKOUT shall last exactly LOCK_CYCLES cycles, then return to IDLE.
REQ-027 digit_valid in UNLOCKED, DENIED or LOCKOUT shall be ignored and shall not extend the hold timer.
REQ-028 One down-counter shall be shared by the timed states; it shall load on entry to each timed state and be sized $clog2 of the larger of HOLD_CYCLES and LOCK_CYCLES.
REQ-029 entered and digit_count shall hold their CHECK values through UNLOCKED/DENIED/LOCKOUT for display.
REQ-030 Undefined state encodings shall recover to IDLE on the next edge.

Reset
REQ-031 With rst=0, the block shall immediately and asynchronously force state=IDLE, entered=0, digit_count=0, fail_count=0, unlocked=0, denied=0, locked_out=0, and timer=0.
REQ-032 Reset asserted mid-entry, mid-hold or mid-lockout shall abort the operation with no residual state; the first valid digit after release shall start a fresh entry.

Verification (test parameters: HOLD_CYCLES=4, LOCK_CYCLES=8, MAX_TRIES=3)
REQ-033 Digits 1,2,3,4 as isolated pulses -> CHECK for 1 cycle, unlocked=1 for exactly 4 cycles, entered=16'h1234, fail_count=0, then IDLE.
REQ-034 Digits 1,2,3,5 -> denied=1 for 4 cycles, fail_count=1; a pulse injected during DENIED has no effect.
REQ-035 Three wrong entries back-to-back -> fail_count 1, 2, then locked_out=1 for exactly 8 cycles with fail_count=0; correct code entered after lockout -> unlocked=1.
REQ-036 Digits 1, 4'hB, 2, 3, 4 -> 4'hB ignored, digit_count=4 only after digit 4, unlocked=1.
REQ-037 rst pulsed low after 2 digits and again during LOCKOUT -> all outputs 0 asynchronously; the next 1,2,3,4 unlocks.
REQ-038 Two failures, then a correct code -> fail_count returns to 0; three more failures are needed to reach LOCKOUT.
